// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity codes and frame length helper
// for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Cycles with tx_start high: data bits + optional parity + start/stop framing.
    function automatic logic [3:0] frame_len(input logic dnum, input logic [1:0] par);
        logic pe;
        pe = (par == PAR_ODD) || (par == PAR_EVEN);
        return 4'd9 + {3'b000, dnum} + {3'b000, pe};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or
// after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            valid
);

    logic [IDW-1:0] slot;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        slot  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            slot = IDW'((int'(ptr) + i) % NREQ);
            if (req[slot]) begin
                valid = 1'b1;
                idx   = slot;
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one UART transmitter;
// owns frame timing (start high for L cycles, then GAP_CYCLES idle).
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 2,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*8-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    input  logic                cfg_dnum,
    input  logic                cfg_snum,
    input  logic [1:0]          cfg_par,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                tx_dnum,
    output logic                tx_snum,
    output logic [1:0]          tx_par,
    output logic                busy,
    output logic [IDW-1:0]      grant_id,
    output logic                frame_done
);

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [3:0]      gcnt, gcnt_n;
    logic [IDW-1:0]  ptr, ptr_n;

    logic [NREQ-1:0] ack_n;
    logic            tx_start_n;
    logic [7:0]      tx_data_n;
    logic            tx_dnum_n;
    logic            tx_snum_n;
    logic [1:0]      tx_par_n;
    logic            busy_n;
    logic [IDW-1:0]  grant_id_n;
    logic            frame_done_n;
    logic            do_grant;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        gcnt_n       = gcnt;
        ptr_n        = ptr;
        ack_n        = '0;
        tx_start_n   = 1'b0;
        tx_data_n    = tx_data;
        tx_dnum_n    = tx_dnum;
        tx_snum_n    = tx_snum;
        tx_par_n     = tx_par;
        busy_n       = busy;
        grant_id_n   = grant_id;
        frame_done_n = 1'b0;
        do_grant     = 1'b0;

        case (state)
            IDLE: begin
                do_grant = en && arb_valid;
            end
            SEND: begin
                tx_start_n = 1'b1;
                cnt_n      = cnt - 4'd1;
                if (cnt == 4'd0) begin
                    tx_start_n = 1'b0;
                    gcnt_n     = 4'(GAP_CYCLES - 1);
                    state_n    = GAP;
                end
            end
            GAP: begin
                gcnt_n = gcnt - 4'd1;
                // Registered pulse lands on the cycle where gcnt reaches zero.
                if (gcnt == 4'd1) begin
                    frame_done_n = 1'b1;
                end
                if (gcnt == 4'd0) begin
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                    // Granting here keeps back-to-back gaps at exactly GAP_CYCLES.
                    do_grant = en && arb_valid;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (do_grant) begin
            ack_n      = arb_gnt;
            tx_data_n  = req_data[arb_idx*8 +: 8];
            tx_dnum_n  = cfg_dnum;
            tx_snum_n  = cfg_snum;
            tx_par_n   = cfg_par;
            grant_id_n = arb_idx;
            tx_start_n = 1'b1;
            busy_n     = 1'b1;
            cnt_n      = frame_len(cfg_dnum, cfg_par) - 4'd1;
            ptr_n      = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
            state_n    = SEND;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            gcnt       <= '0;
            ptr        <= '0;
            ack        <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            tx_dnum    <= 1'b0;
            tx_snum    <= 1'b0;
            tx_par     <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            gcnt       <= gcnt_n;
            ptr        <= ptr_n;
            ack        <= ack_n;
            tx_start   <= tx_start_n;
            tx_data    <= tx_data_n;
            tx_dnum    <= tx_dnum_n;
            tx_snum    <= tx_snum_n;
            tx_par     <= tx_par_n;
            busy       <= busy_n;
            grant_id   <= grant_id_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - table-driven and scoreboard bench for uart_tx_scheduler.
module tb_uart_tx_scheduler;

    localparam int NREQ    = 4;
    localparam int GAP_CYC = 2;
    localparam int IDW     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*8-1:0] req_data = '0;
    logic              cfg_dnum = 1'b0;
    logic              cfg_snum = 1'b0;
    logic [1:0]        cfg_par = 2'b00;
    logic [NREQ-1:0]   ack;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_dnum;
    logic              tx_snum;
    logic [1:0]        tx_par;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic              frame_done;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .cfg_dnum   (cfg_dnum),
        .cfg_snum   (cfg_snum),
        .cfg_par    (cfg_par),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_dnum    (tx_dnum),
        .tx_snum    (tx_snum),
        .tx_par     (tx_par),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0] req;
        logic [7:0] data;
        logic       dnum;
        logic       snum;
        logic [1:0] par;
        int         id;
        int         len;
        bit         mid;
    } vec_t;

    typedef struct {
        int         len;
        logic [7:0] data;
        int         id;
        logic       dnum;
        logic       snum;
        logic [1:0] par;
    } exp_t;

    exp_t sb_q[$];
    int   gaps_q[$];
    vec_t tbl[8];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   fd_cnt = 0;
    bit   mon_prev = 1'b0;
    int   mon_hi = 0;
    int   mon_lo = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane(input logic [7:0] d, input int i);
        return d ^ (8'(i) * 8'h11);
    endfunction

    task automatic check_frame(input int hi);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_frame actual_len=%0d expected=none", hi);
            return;
        end
        e = sb_q.pop_front();
        chk("frame_len", hi, e.len);
        chk("tx_data", tx_data, e.data);
        chk("grant_id", grant_id, e.id);
        chk("tx_dnum", tx_dnum, e.dnum);
        chk("tx_snum", tx_snum, e.snum);
        chk("tx_par", tx_par, e.par);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_prev = 1'b0;
                mon_hi   = 0;
                mon_lo   = 0;
            end else if (mon_en) begin
                if (frame_done) fd_cnt++;
                if (tx_start) begin
                    if (!mon_prev) gaps_q.push_back(mon_lo);
                    mon_hi++;
                    mon_lo = 0;
                end else begin
                    if (mon_prev) check_frame(mon_hi);
                    mon_hi = 0;
                    mon_lo++;
                end
                mon_prev = tx_start;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < 50);
    endtask

    task automatic push_exp(input int len, input logic [7:0] data, input int id,
                            input logic dnum, input logic snum, input logic [1:0] par);
        exp_t e;
        e.len = len; e.data = data; e.id = id; e.dnum = dnum; e.snum = snum; e.par = par;
        sb_q.push_back(e);
    endtask

    task automatic drive_cfg(input logic [7:0] base, input logic dnum, input logic snum,
                             input logic [1:0] par);
        cfg_dnum = dnum;
        cfg_snum = snum;
        cfg_par  = par;
        for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = lane(base, i);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        wait_idle();
        @(negedge clk);
        drive_cfg(v.data, v.dnum, v.snum, v.par);
        req = v.req;
        push_exp(v.len, lane(v.data, v.id), v.id, v.dnum, v.snum, v.par);
        wait_ack();
        chk("ack_onehot", ack, 32'(1) << v.id);
        chk("start_with_ack", tx_start, 1);
        chk("busy_with_ack", busy, 1);
        @(negedge clk);
        req = '0;
        chk("ack_pulse", ack, 0);
        if (v.mid) begin
            repeat (2) @(negedge clk);
            cfg_par  = 2'b01;
            req_data = ~req_data;
            en       = 1'b0;
        end
        n = 0;
        while (tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_fall", tx_start, 0);
        chk("gap1_busy", busy, 1);
        chk("gap1_done", frame_done, 0);
        @(negedge clk);
        chk("gap2_busy", busy, 1);
        chk("gap2_done", frame_done, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", frame_done, 0);
        en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n, k, fd0, n_ack;
        int rot_ids[5];
        vec_t v;

        tbl[0] = '{4'b0001, 8'hA5, 1'b1, 1'b0, 2'b00, 0, 10, 1'b0};
        tbl[1] = '{4'b0010, 8'h3C, 1'b1, 1'b0, 2'b01, 1, 11, 1'b0};
        tbl[2] = '{4'b0100, 8'h5A, 1'b0, 1'b1, 2'b10, 2, 10, 1'b0};
        tbl[3] = '{4'b1000, 8'h7E, 1'b0, 1'b0, 2'b00, 3,  9, 1'b0};
        tbl[4] = '{4'b0001, 8'h81, 1'b0, 1'b0, 2'b11, 0,  9, 1'b0};
        tbl[5] = '{4'b0101, 8'hC3, 1'b1, 1'b1, 2'b10, 2, 11, 1'b0};
        tbl[6] = '{4'b0001, 8'hD2, 1'b1, 1'b0, 2'b00, 0, 10, 1'b1};
        tbl[7] = '{4'b0001, 8'hFF, 1'b1, 1'b0, 2'b01, 0, 11, 1'b0};
        rot_ids = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_cfg", {tx_dnum, tx_snum, tx_par}, 0);
        chk("rst_grant_id", grant_id, 0);
        rst    = 1'b1;
        en     = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        wait_idle();
        mon_en = 1'b0;
        @(negedge clk);
        drive_cfg(8'h90, 1'b1, 1'b0, 2'b00);
        req = 4'b0100;
        wait_ack();
        chk("rstmid_ack", ack, 4'b0100);
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        chk("rstmid_pre_start", tx_start, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_tx_start", tx_start, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ack0", ack, 0);
        chk("rstmid_grant_id", grant_id, 0);
        chk("rstmid_tx_data", tx_data, 0);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        rst    = 1'b1;
        v = '{4'b0010, 8'h44, 1'b1, 1'b0, 2'b00, 1, 10, 1'b0};
        run_vec(v);

        wait_idle();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        gaps_q.delete();
        fd0 = fd_cnt;
        @(negedge clk);
        drive_cfg(8'h60, 1'b1, 1'b0, 2'b00);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) push_exp(10, lane(8'h60, rot_ids[i]), rot_ids[i], 1'b1, 1'b0, 2'b00);
        k = 0;
        n = 0;
        while (k < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (ack != '0) begin
                chk("rot_ack", ack, 32'(1) << rot_ids[k]);
                k++;
            end
        end
        req = '0;
        chk("rot_count", k, 5);
        wait_idle();
        @(negedge clk);
        chk("rot_rises", gaps_q.size(), 5);
        if (gaps_q.size() == 5) begin
            for (int i = 1; i < 5; i++) chk("rot_gap", gaps_q[i], GAP_CYC);
        end
        chk("rot_frame_done", fd_cnt - fd0, 5);

        wait_idle();
        @(negedge clk);
        en = 1'b0;
        drive_cfg(8'hB4, 1'b0, 1'b0, 2'b01);
        req = 4'b0100;
        push_exp(10, lane(8'hB4, 2), 2, 1'b0, 1'b0, 2'b01);
        n_ack = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack != '0) n_ack++;
        end
        chk("en_low_no_ack", n_ack, 0);
        en = 1'b1;
        @(negedge clk);
        chk("en_ack", ack, 4'b0100);
        @(negedge clk);
        req = '0;
        wait_idle();
        repeat (2) @(negedge clk);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
